// File: rtl/reg_sel_sequencer.sv
// Registered one-hot select generator: direct address decode or programmable scan with dwell.
// Optional SEL_TRISTATE_EN: sel floats while enable was sampled low and during reset.
module reg_sel_sequencer #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned NUM_SEL = 16,
  parameter int unsigned DWELL   = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               mode,
  input  logic [ADDR_W-1:0]  addr,
  input  logic               start,
  input  logic [ADDR_W:0]    len,
  output logic [NUM_SEL-1:0] sel,
  output logic [ADDR_W-1:0]  cur_addr,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int unsigned      DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [ADDR_W:0]  NUM_SEL_W  = (ADDR_W + 1)'(NUM_SEL);
  localparam logic [ADDR_W:0]  CNT_ONE    = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SEL - 1);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e             state_q;
  logic [NUM_SEL-1:0] sel_q;
  logic [ADDR_W:0]    count_q;
  logic [DW_W-1:0]    dwell_q;

  logic               addr_oor;
  logic [ADDR_W:0]    len_clamped;
  logic [ADDR_W-1:0]  next_addr;

  function automatic logic [NUM_SEL-1:0] onehot(input logic [ADDR_W-1:0] a);
    return NUM_SEL'(1) << a;
  endfunction

  assign addr_oor    = ({1'b0, addr} >= NUM_SEL_W);
  assign len_clamped = (len > NUM_SEL_W) ? NUM_SEL_W : len;
  assign next_addr   = (cur_addr == LAST_ADDR) ? '0 : cur_addr + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      sel_q    <= '0;
      cur_addr <= '0;
      count_q  <= '0;
      dwell_q  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else if (!enable) begin
      // Abort: drop everything without a done pulse; cur_addr keeps its last value.
      state_q <= StIdle;
      sel_q   <= '0;
      count_q <= '0;
      dwell_q <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          dwell_q <= '0;
          if (!mode) begin
            if (addr_oor) begin
              sel_q <= '0;
              err   <= 1'b1;
            end else begin
              sel_q    <= onehot(addr);
              cur_addr <= addr;
              err      <= 1'b0;
            end
          end else begin
            sel_q <= '0;
            err   <= 1'b0;
            if (start) begin
              cur_addr <= addr_oor ? '0 : addr;
              err      <= addr_oor;
              count_q  <= len_clamped;
              state_q  <= (len == '0) ? StDone : StScan;
            end
          end
        end
        StScan: begin
          sel_q <= onehot(cur_addr);
          busy  <= 1'b1;
          err   <= 1'b0;
          if (dwell_q == DWELL_LAST) begin
            dwell_q <= '0;
            count_q <= count_q - 1'b1;
            if (count_q <= CNT_ONE) begin
              state_q <= StDone;
            end else begin
              cur_addr <= next_addr;
            end
          end else begin
            dwell_q <= dwell_q + 1'b1;
          end
        end
        StDone: begin
          sel_q   <= '0;
          busy    <= 1'b0;
          done    <= 1'b1;
          err     <= 1'b0;
          count_q <= '0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          sel_q   <= '0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

`ifdef SEL_TRISTATE_EN
  logic sel_z_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_z_q <= 1'b1;
    end else begin
      sel_z_q <= !enable;
    end
  end

  assign sel = sel_z_q ? {NUM_SEL{1'bz}} : sel_q;
`else
  assign sel = sel_q;
`endif

endmodule

// File: tb/tb_reg_sel_sequencer.sv
// Directed self-checking bench for reg_sel_sequencer (16-select/dwell-2 and 10-select instances).
module tb_reg_sel_sequencer;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        mode;
  logic [3:0]  addr;
  logic        start;
  logic [4:0]  len;

  logic [15:0] sel;
  logic [3:0]  cur_addr;
  logic        busy, done, err;

  logic [9:0]  sel10;
  logic [3:0]  cur_addr10;
  logic        busy10, done10, err10;

  int checks = 0;
  int errors = 0;

`ifdef SEL_TRISTATE_EN
  localparam logic [15:0] SEL_OFF = 16'hzzzz;
`else
  localparam logic [15:0] SEL_OFF = 16'h0000;
`endif

  reg_sel_sequencer #(.ADDR_W(4), .NUM_SEL(16), .DWELL(2)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .addr(addr), .start(start),
    .len(len), .sel(sel), .cur_addr(cur_addr), .busy(busy), .done(done), .err(err)
  );

  reg_sel_sequencer #(.ADDR_W(4), .NUM_SEL(10), .DWELL(1)) u_dut10 (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .addr(addr), .start(start),
    .len(len), .sel(sel10), .cur_addr(cur_addr10), .busy(busy10), .done(done10), .err(err10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [15:0] exp_wrap [8] = '{16'h4000, 16'h4000, 16'h8000, 16'h8000,
                                16'h0001, 16'h0001, 16'h0002, 16'h0002};
  logic [15:0] exp_sel;

  initial begin
    reset = 1'b1; enable = 1'b0; mode = 1'b0; addr = '0; start = 1'b0; len = '0;
    #2;
    chk("rst_sel", 32'(sel), 32'(SEL_OFF));
    chk("rst_cur", 32'(cur_addr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    step();
    reset = 1'b0;

    // Direct decode
    enable = 1'b1; addr = 4'h5;
    step();
    chk("dir5_sel", 32'(sel), 32'h0020);
    chk("dir5_err", 32'(err), 0);
    chk("dir5_cur", 32'(cur_addr), 5);
    chk("dir5_sel10", 32'(sel10), 32'h020);
    addr = 4'hF;
    step();
    chk("dirF_sel", 32'(sel), 32'h8000);
    chk("dirF_sel10", 32'(sel10), 0);
    chk("dirF_err10", 32'(err10), 1);
    chk("dirF_cur10", 32'(cur_addr10), 5);
    addr = 4'hC;
    step();
    chk("dirC_sel", 32'(sel), 32'h1000);
    chk("dirC_err", 32'(err), 0);
    chk("dirC_sel10", 32'(sel10), 0);
    chk("dirC_err10", 32'(err10), 1);
    chk("dirC_cur10", 32'(cur_addr10), 5);
    addr = 4'h3;
    step();
    chk("dir3_sel10", 32'(sel10), 32'h008);
    chk("dir3_err10", 32'(err10), 0);

    // Scan with wrap: base 14, len 4, dwell 2; a start pulse mid-scan must be ignored
    mode = 1'b1; addr = 4'd14; len = 5'd4; start = 1'b1;
    step();
    start = 1'b0;
    chk("wrap_k_busy", 32'(busy), 0);
    chk("wrap_k_sel", 32'(sel), 0);
    chk("wrap_k_err10", 32'(err10), 1);
    for (int i = 0; i < 8; i++) begin
      start = (i == 2);
      addr  = (i == 2) ? 4'd3 : 4'd14;
      step();
      chk($sformatf("wrap_sel%0d", i), 32'(sel), 32'(exp_wrap[i]));
      chk($sformatf("wrap_busy%0d", i), 32'(busy), 1);
      chk($sformatf("wrap_done%0d", i), 32'(done), 0);
      if (i == 0) chk("wrap_err10_clr", 32'(err10), 0);
    end
    start = 1'b0;
    step();
    chk("wrap_done", 32'(done), 1);
    chk("wrap_done_busy", 32'(busy), 0);
    chk("wrap_done_sel", 32'(sel), 0);
    step();
    chk("wrap_done_pulse", 32'(done), 0);

    // len = 0: done one cycle after start, no select
    addr = 4'd3; len = 5'd0; start = 1'b1;
    step();
    start = 1'b0;
    chk("len0_k_done", 32'(done), 0);
    chk("len0_k_sel", 32'(sel), 0);
    step();
    chk("len0_done", 32'(done), 1);
    chk("len0_sel", 32'(sel), 0);
    chk("len0_busy", 32'(busy), 0);
    step();
    chk("len0_done_clr", 32'(done), 0);

    // len = 20 clamps to 16 addresses
    addr = 4'd0; len = 5'd20; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      step();
      exp_sel = 16'h0001 << (i / 2);
      chk($sformatf("clamp_sel%0d", i), 32'(sel), 32'(exp_sel));
      chk($sformatf("clamp_done%0d", i), 32'(done), 0);
    end
    step();
    chk("clamp_done", 32'(done), 1);
    chk("clamp_sel_end", 32'(sel), 0);
    step();

    // Abort at the third scan address
    addr = 4'd0; len = 5'd8; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("abort_pre_sel", 32'(sel), 32'h0004);
    chk("abort_pre_busy", 32'(busy), 1);
    enable = 1'b0;
    step();
    chk("abort_sel", 32'(sel), 32'(SEL_OFF));
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    enable = 1'b1;
    step();
    chk("abort_re_sel", 32'(sel), 0);
    chk("abort_re_done", 32'(done), 0);
    step();
    chk("abort_re_done2", 32'(done), 0);
    chk("abort_re_busy", 32'(busy), 0);

    // Asynchronous reset mid-scan
    addr = 4'd2; len = 5'd5; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("rscan_sel", 32'(sel), 32'h0004);
    chk("rscan_busy", 32'(busy), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("rmid_sel", 32'(sel), 32'(SEL_OFF));
    chk("rmid_busy", 32'(busy), 0);
    chk("rmid_cur", 32'(cur_addr), 0);
    chk("rmid_done", 32'(done), 0);
    step();
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
